// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receive controller: prescaled tick generation, start-bit
// qualification, mid-bit sampling and LSB-first byte assembly with result pulses.
module uart_rx_ctrl #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  rxc_clk,
  input  logic                  rxc_rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  rx_in,
  output logic [DATA_BITS-1:0]  rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BIT_LAST     = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                state, state_n;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic [OS_W-1:0]       os_cnt, os_n;
  logic [BC_W-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic [DATA_BITS-1:0]  data_n;
  logic                  valid_n, ferr_n;

  // >= rather than == so a prescale lowered below pcnt still produces a tick
  assign tick = enable && (pcnt >= prescale);
  assign busy = (state != IDLE);

  always_ff @(posedge rxc_clk) begin
    if (!rxc_rst_n) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge rxc_clk) begin
    if (!rxc_rst_n) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_in) state_n = START;
        end
        START: begin
          if (os_cnt == OS_HALF_LAST) state_n = rx_in ? IDLE : DATA;
          else                        os_n = os_cnt + 1'b1;
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            shreg_n = {rx_in, shreg[DATA_BITS-1:1]};
            os_n    = '0;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_n = STOP;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            if (rx_in) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_in) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    // Every state change restarts per-bit and per-frame counting
    if (state_n != state) begin
      os_n  = '0;
      bit_n = '0;
    end
  end

endmodule
